// File: rtl/sub1_pkg.sv
// Shared types for the sub1 feeder: byte/frame/tag types and the byte-index FSM states.
package sub1_pkg;

  localparam int FRAME_BYTES = 3;

  typedef logic [7:0]      byte_t;
  typedef logic [0:2][7:0] frame_t;
  typedef logic [1:0]      tag_t;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/sub1_byte_asm.sv
// Byte-to-frame assembler: tracks the index of the next byte, captures bytes 0/1 and
// flags short/long frames. frame_done is a same-cycle strobe with byte 2 on the frame bus.
module sub1_byte_asm
  import sub1_pkg::*;
#(
  parameter bit STRICT_LAST = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   accept,
  input  byte_t  data,
  input  logic   last,
  input  logic   flush,
  output frame_t frame,
  output logic   frame_done,
  output logic   err
);

  feeder_state_e state;
  byte_t         byte0_q;
  byte_t         byte1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (flush) begin
        state <= B0;
      end else if (accept) begin
        case (state)
          B0: begin
            if (last) err <= 1'b1;
            else      state <= B1;
          end
          B1: begin
            if (last) begin
              err   <= 1'b1;
              state <= B0;
            end else begin
              state <= B2;
            end
          end
          B2: begin
            state <= B0;
            if (STRICT_LAST && !last) err <= 1'b1;
          end
          default: state <= B0;
        endcase
      end
    end
  end

  // Payload registers carry no reset: their contents are only observed through a completed frame.
  always_ff @(posedge clk) begin
    if (accept && state == B0) byte0_q <= data;
    if (accept && state == B1) byte1_q <= data;
  end

  always_comb begin
    frame      = {byte0_q, byte1_q, data};
    frame_done = accept && !flush && (state == B2) && !(STRICT_LAST && !last);
  end

endmodule

// File: rtl/sub1_feeder.sv
// Upstream feeder for sub1: assembles 3-byte frames and drives sub1's registered inputs.
// Optional history (sig_d = previous frame) is built only when SUB1_FEEDER_HIST_EN is defined.
module sub1_feeder
  import sub1_pkg::*;
#(
  parameter bit STRICT_LAST = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  byte_t  in_data,
  input  logic   in_last,
  input  logic   flush,
  output logic   sig_a,
  output tag_t   sig_b,
  output frame_t sig_c,
  output byte_t  sig_d [0:FRAME_BYTES-1],
  output logic   err
);

  logic   accept;
  logic   frame_done;
  frame_t frame;
  tag_t   tag_cnt;

  assign accept = in_valid & in_ready;

  sub1_byte_asm #(
    .STRICT_LAST (STRICT_LAST)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .data       (in_data),
    .last       (in_last),
    .flush      (flush),
    .frame      (frame),
    .frame_done (frame_done),
    .err        (err)
  );

  // Emit stage: outputs move only when the assembler completes a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      sig_a    <= 1'b0;
      sig_b    <= '0;
      sig_c    <= '0;
      tag_cnt  <= '0;
    end else begin
      in_ready <= 1'b1;
      sig_a    <= frame_done;
      if (frame_done) begin
        sig_c   <= frame;
        sig_b   <= tag_cnt;
        tag_cnt <= tag_cnt + 2'd1;
      end
    end
  end

`ifdef SUB1_FEEDER_HIST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_BYTES; i++) sig_d[i] <= '0;
    end else if (frame_done) begin
      for (int i = 0; i < FRAME_BYTES; i++) sig_d[i] <= sig_c[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < FRAME_BYTES; i++) sig_d[i] = '0;
  end
`endif

endmodule

// File: tb/tb_sub1_feeder.sv
// Directed scoreboard bench for sub1_feeder (strict instance fully checked, relaxed instance spot-checked).
module tb_sub1_feeder;
  import sub1_pkg::*;

`ifdef SUB1_FEEDER_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  byte_t  in_data = '0;
  logic   in_last = 1'b0;
  logic   flush = 1'b0;

  logic   in_ready, sig_a, err;
  tag_t   sig_b;
  frame_t sig_c;
  byte_t  sig_d [0:2];

  logic   ns_in_ready, ns_sig_a, ns_err;
  tag_t   ns_sig_b;
  frame_t ns_sig_c;
  byte_t  ns_sig_d [0:2];

  always #5 clk = ~clk;

  sub1_feeder #(.STRICT_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush), .sig_a(sig_a), .sig_b(sig_b), .sig_c(sig_c),
    .sig_d(sig_d), .err(err)
  );

  sub1_feeder #(.STRICT_LAST(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush), .sig_a(ns_sig_a), .sig_b(ns_sig_b), .sig_c(ns_sig_c),
    .sig_d(ns_sig_d), .err(ns_err)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [23:0] cur;
    logic [23:0] prev;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          midx = 0;
  logic [7:0]  mb0, mb1;
  logic [1:0]  mtag = 2'd0;
  logic [1:0]  mtag_out = 2'd0;
  logic [23:0] mcur = '0;
  logic [23:0] mprev = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic fl);
    logic e_emit, e_err;
    exp_t it;
    e_emit = 1'b0;
    e_err  = 1'b0;
    in_valid = v; in_data = d; in_last = l; flush = fl;
    if (fl) begin
      midx = 0;
    end else if (v) begin
      case (midx)
        0: begin mb0 = d; if (l) e_err = 1'b1; else midx = 1; end
        1: begin mb1 = d; if (l) begin e_err = 1'b1; midx = 0; end else midx = 2; end
        default: begin
          midx = 0;
          if (!l) e_err = 1'b1;
          else begin
            e_emit  = 1'b1;
            it.tag  = mtag;
            it.cur  = {mb0, mb1, d};
            it.prev = HIST ? mcur : 24'h0;
            q.push_back(it);
            mprev = it.prev; mcur = it.cur; mtag_out = mtag; mtag = mtag + 2'd1;
          end
        end
      endcase
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    chk("in_ready", in_ready, 1'b1);
    chk("sig_a", sig_a, e_emit);
    chk("err", err, e_err);
    if (sig_a) begin
      chk("sb_pending", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        it = q.pop_front();
        chk("sig_b", sig_b, it.tag);
        chk("sig_c", sig_c, it.cur);
        chk("sig_d", {sig_d[0], sig_d[1], sig_d[2]}, it.prev);
      end
    end else begin
      chk("hold_b", sig_b, mtag_out);
      chk("hold_c", sig_c, mcur);
      chk("hold_d", {sig_d[0], sig_d[1], sig_d[2]}, mprev);
    end
  endtask

  task automatic frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_sig_a", sig_a, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sig_b", sig_b, 2'd0);
    chk("rst_sig_c", sig_c, 24'h0);
    chk("rst_sig_d", {sig_d[0], sig_d[1], sig_d[2]}, 24'h0);
    rst = 1'b0;
    midx = 0; mtag = 2'd0; mtag_out = 2'd0; mcur = '0; mprev = '0;
    q.delete();
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_sig_a", sig_a, 1'b0);
  endtask

  initial begin
    do_reset();

    // First frame after reset.
    frame3(8'h11, 8'h22, 8'h33);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Five back-to-back frames starting from a fresh tag.
    do_reset();
    for (int f = 0; f < 5; f++)
      frame3(8'(8'h40 + 3 * f), 8'(8'h41 + 3 * f), 8'(8'h42 + 3 * f));
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Short frame: in_last on byte 1.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Long frame: no in_last on byte 2; relaxed instance emits it.
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    step(1'b1, 8'h63, 1'b0, 1'b0);
    chk("ns_sig_a", ns_sig_a, 1'b1);
    chk("ns_sig_c", ns_sig_c, 24'h616263);
    chk("ns_err", ns_err, 1'b0);
    frame3(8'h71, 8'h72, 8'h73);

    // Flush after two bytes, then a clean frame.
    step(1'b1, 8'h81, 1'b0, 1'b0);
    step(1'b1, 8'h82, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    frame3(8'hAA, 8'hBB, 8'hCC);

    // Flush coincident with the third byte suppresses the emit.
    step(1'b1, 8'h91, 1'b0, 1'b0);
    step(1'b1, 8'h92, 1'b0, 1'b0);
    step(1'b1, 8'h93, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    frame3(8'hD1, 8'hD2, 8'hD3);

    // Reset mid-frame, then a full frame restarts the tag at 0.
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    do_reset();
    frame3(8'h5A, 8'h5B, 8'h5C);
    frame3(8'h6A, 8'h6B, 8'h6C);
    frame3(8'h7A, 8'h7B, 8'h7C);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sub1_feeder.md
# sub1_feeder

Upstream stage for `sub1`. It accepts a valid/ready byte stream and assembles each group of three bytes into a frame. It then drives `sub1`'s four inputs from registers: `sig_a` is a frame strobe, `sig_b` is a 2-bit sequence tag, `sig_c` is the packed frame and `sig_d` is the unpacked previous frame. All outputs are registered and hold between frames, so `sub1` connects directly with no glue logic.

## Interface
- `STRICT_LAST`, default 1: when 1, the third byte must carry `in_last`; when 0, `in_last` on the third byte is ignored.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: **one clock; reset is synchronous and active-high**.
- `in_valid` in 1: byte offered.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `in_data` in 8: byte payload.
- `in_last` in 1: marks the final byte of a frame.
- `flush` in 1: abandons the partial frame.
- `sig_a` out 1: one-cycle strobe, new frame on `sig_c`.
- `sig_b` out [1:0]: sequence tag of the frame on `sig_c`.
- `sig_c` out [0:2][7:0]: current frame; index 0 is the first byte received.
- `sig_d` out [7:0] x[3]: previous frame, unpacked, same index order.
- `err` out 1: one-cycle framing-error pulse.

## Operation
- FSM states `B0`, `B1`, `B2` hold the index of the next byte. An accept means `in_valid & in_ready`.
- `B0` accept: capture byte 0.
  - `in_last=1`: short frame, pulse `err`, stay in `B0`.
  - Otherwise go to `B1`.
- `B1` accept: the same rules apply to byte 1, going to `B2`.
- `B2` accept: capture byte 2, then go to `B0`.
  - If `STRICT_LAST=1` and `in_last=0`: long frame, pulse `err`, drop the frame, no emit.
  - Otherwise emit the frame.
- Emit updates, on the next edge:
  - `sig_c` gets the new frame.
  - `sig_d` gets the old `sig_c`.
  - `sig_b` gets the internal sequence counter, and the counter increments.
  - `sig_a` is 1 for one cycle.
- The sequence counter is 2 bits and wraps from 3 to 0. The first frame after reset carries tag 0. Dropped frames do not advance it.
- `flush` has priority over everything except `rst`:
  - State goes to `B0` and captured bytes are discarded.
  - A byte accepted in the same cycle is consumed and dropped.
  - No `err` pulse; `sig_b`, `sig_c` and `sig_d` are unchanged.
  - A `flush` in the cycle that would emit suppresses the emit.
- `in_ready` is registered: 0 during reset and 1 in every cycle afterwards. The block never backpressures.

## Timing
- Reset values: `in_ready`, `sig_a`, `sig_b`, `err` = 0; `sig_c`, `sig_d` = all zeros; state `B0`; counter 0.
- `rst` asserted mid-frame behaves as in the reset values above, with no `err` pulse.
- Latency: `sig_a` rises on the edge after the third byte is accepted. `sig_b`, `sig_c` and `sig_d` change on that same edge.
- `err` asserts on the edge after the offending accept.
- Throughput: one byte per cycle, so one frame every 3 cycles, with back-to-back `sig_a` strobes 3 cycles apart.
- Outputs only change on an emit.

## Configuration
- Macro: `SUB1_FEEDER_HIST_EN`.
- Defined: `sig_d` carries the previous frame as described above.
- Undefined: the history registers are removed and `sig_d` is constant zero, including after emits. All other behaviour is identical.

## Structure
- Package `sub1_pkg` holds:
  - `FRAME_BYTES = 3`.
  - `byte_t` (logic [7:0]).
  - `frame_t` (logic [0:2][7:0]).
  - `tag_t` (logic [1:0]).
  - The FSM state enum `feeder_state_e`.
- `sub1` ports are to be re-expressed in these types.
- One sub-module: `sub1_byte_asm`. It contains the FSM and the byte capture registers, and outputs the captured frame plus a `frame_done` strobe and an `err` strobe.
- The top level holds the tag counter, output registers and history registers.

## Test plan
- Reset release, then stream bytes 0x11, 0x22, 0x33 with `in_last` on 0x33 → one cycle later `sig_a=1`, `sig_c={11,22,33}`, `sig_b=0`, `sig_d` all zeros.
- Five consecutive valid frames → `sig_b` reads 0,1,2,3,0; `sig_a` strobes every 3 cycles; each `sig_d` equals the prior `sig_c`.
- Framing errors:
  - `in_last` on byte 1 → `err` pulses, no `sig_a`.
  - `STRICT_LAST=1` with no `in_last` on byte 2 → `err` pulses, no `sig_a`, tag not advanced.
  - With `STRICT_LAST=0`, the second case emits normally.
- `flush` after 2 bytes, then a full frame 0xAA, 0xBB, 0xCC → `sig_c={AA,BB,CC}`, no `err`; `flush` coincident with the third byte → no emit.
- `rst` asserted after 1 byte, then a full frame → `sig_b=0`, `sig_c` equals the new bytes, `in_ready` is 0 for the reset cycle.
- Build without `SUB1_FEEDER_HIST_EN` → `sig_d` stays 0 across three frames; all other checks pass.
